// File: rtl/regwrite_arbiter_pkg.sv
// regwrite_arbiter_pkg: shared pipeline types for register-file writeback arbitration
package regwrite_arbiter_pkg;
  localparam int REG_W = 5;
  localparam int NREGS = 1 << REG_W;
  typedef logic [REG_W-1:0] reg_idx_t;
  typedef enum logic {NORMAL, FORCE_B} arb_state_t;
endpackage

// File: rtl/regwrite_scoreboard.sv
// regwrite_scoreboard: pending-destination tracking, hazard stall and double-issue detection
module regwrite_scoreboard
  import regwrite_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     issue_valid,
  input  reg_idx_t issue_rd,
  input  logic     clr_valid,
  input  reg_idx_t clr_rd,
  input  reg_idx_t rs,
  input  reg_idx_t rt,
  output logic     stall,
  output logic     issue_err
);
  localparam logic [NREGS-1:0] ONE = NREGS'(1);
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic             set_en;
  logic             clr_hit;
  assign set_en   = issue_valid && issue_rd != '0;
  assign set_mask = set_en ? ONE << issue_rd : '0;
  assign clr_mask = clr_valid ? ONE << clr_rd : '0;
  assign clr_hit  = clr_valid && clr_rd == issue_rd;
  assign stall    = (rs != '0 && pending[rs]) || (rt != '0 && pending[rt]);
  // set is OR-ed after the clear so a same-cycle issue of the retiring rd keeps it pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      issue_err <= 1'b0;
    end else begin
      pending   <= ((pending & ~clr_mask) | set_mask) & ~ONE;
      issue_err <= set_en && pending[issue_rd] && !clr_hit;
    end
  end
endmodule

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: two-requester register-file write port arbiter with B starvation guard
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  reg_idx_t    a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  reg_idx_t    b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        rf_regwrite,
  output reg_idx_t    rf_rd,
  output logic [31:0] rf_writedata,
  input  logic        issue_valid,
  input  reg_idx_t    issue_rd,
  input  reg_idx_t    rs,
  input  reg_idx_t    rt,
  output logic        stall,
  output logic        issue_err
);
  localparam int CW = $clog2(MAX_WAIT + 2);
  localparam logic [CW-1:0] MAXC = CW'(MAX_WAIT);
  arb_state_t  state;
  arb_state_t  state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic        b_wait;
  logic        a_fire;
  logic        b_fire;
  logic        wr_en;
  reg_idx_t    wr_rd;
  logic [31:0] wr_data;
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    state_n = NORMAL;
    if (rst_n) begin
      b_ready = state == FORCE_B ? 1'b1 : !a_valid && b_valid;
      a_ready = state == FORCE_B ? !b_valid : a_valid;
    end
    b_wait  = b_valid && !b_ready;
    cnt_n   = !b_wait ? '0 : (cnt >= MAXC ? MAXC : cnt + 1'b1);
    state_n = (state == NORMAL && b_wait && cnt_n >= MAXC) ? FORCE_B : NORMAL;
  end
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;
  assign wr_rd   = b_fire ? b_rd : a_rd;
  assign wr_data = b_fire ? b_data : a_data;
  assign wr_en   = (a_fire || b_fire) && wr_rd != '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= NORMAL;
      cnt          <= '0;
      rf_regwrite  <= 1'b0;
      rf_rd        <= '0;
      rf_writedata <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rf_regwrite <= wr_en;
      if (wr_en) begin
        rf_rd        <= wr_rd;
        rf_writedata <= wr_data;
      end
    end
  end
  regwrite_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .clr_valid   (b_fire),
    .clr_rd      (b_rd),
    .rs          (rs),
    .rt          (rt),
    .stall       (stall),
    .issue_err   (issue_err)
  );
endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: randomized scoreboard bench against an abstract writeback/hazard model
module tb_regwrite_arbiter;
  localparam int MW = 4;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_rd, b_rd, issue_rd, rs, rt, rf_rd;
  logic [31:0] a_data, b_data, rf_writedata;
  logic        a_ready, b_ready, rf_regwrite, stall, issue_err;
  typedef struct packed {logic [4:0] rd; logic [31:0] d;} wr_t;
  wr_t q[$];
  bit   pend[32];
  int   w = 0;
  int   nvec = 0;
  int   nerr = 0;
  bit   armed = 0;
  bit   was_reset = 0;
  always #5 clk = ~clk;
  regwrite_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_regwrite(rf_regwrite), .rf_rd(rf_rd), .rf_writedata(rf_writedata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs(rs), .rt(rt), .stall(stall), .issue_err(issue_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // one clock of stimulus; B wins when it has already waited MW cycles or A is idle
  task automatic cyc(input logic rn, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic bv, input logic [4:0] br, input logic [31:0] bd,
                     input logic iv, input logic [4:0] ir, input logic [4:0] rs_i, input logic [4:0] rt_i);
    bit b_win, a_win, e_err, e_stall;
    rst_n = rn; a_valid = av; a_rd = ar; a_data = ad;
    b_valid = bv; b_rd = br; b_data = bd;
    issue_valid = iv; issue_rd = ir; rs = rs_i; rt = rt_i;
    #1;
    b_win = rn && bv && (!av || w == MW);
    a_win = rn && av && !b_win;
    chk("a_fire", 32'(a_valid & a_ready), 32'(a_win));
    chk("b_fire", 32'(b_valid & b_ready), 32'(b_win));
    if (!rn) begin
      chk("a_ready_in_reset", 32'(a_ready), 32'd0);
      chk("b_ready_in_reset", 32'(b_ready), 32'd0);
    end
    if (armed) begin
      e_stall = (rs_i != 0 && pend[rs_i]) || (rt_i != 0 && pend[rt_i]);
      chk("stall", 32'(stall), 32'(e_stall));
    end
    e_err = rn && iv && ir != 0 && pend[ir] && !(b_win && br == ir);
    if (a_win && ar != 0) q.push_back('{ar, ad});
    if (b_win && br != 0) q.push_back('{br, bd});
    if (!rn) begin
      foreach (pend[i]) pend[i] = 0;
      w = 0;
    end else begin
      if (b_win) pend[br] = 0;
      if (iv && ir != 0) pend[ir] = 1;
      w = (bv && !b_win) ? ((w + 1 > MW) ? MW : w + 1) : 0;
    end
    @(posedge clk);
    #1;
    was_reset = !rn;
    armed = 1;
    chk("issue_err", 32'(issue_err), 32'(e_err));
  endtask
  task automatic idle(input logic [4:0] rs_i, input logic [4:0] rt_i);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, rs_i, rt_i);
  endtask
  initial begin : monitor
    logic [4:0]  last_rd;
    logic [31:0] last_d;
    wr_t e;
    last_rd = '0;
    last_d  = '0;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (was_reset) begin
          last_rd = '0;
          last_d  = '0;
          chk("rf_regwrite_after_reset", 32'(rf_regwrite), 32'd0);
          chk("rf_rd_after_reset", 32'(rf_rd), 32'd0);
          chk("rf_writedata_after_reset", rf_writedata, 32'd0);
        end else if (rf_regwrite === 1'b1) begin
          if (q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_write: got rd %0d data %0h, expected no write", rf_rd, rf_writedata);
          end else begin
            e = q.pop_front();
            chk("rf_rd", 32'(rf_rd), 32'(e.rd));
            chk("rf_writedata", rf_writedata, e.d);
            last_rd = e.rd;
            last_d  = e.d;
          end
        end else begin
          chk("rf_regwrite_idle", 32'(rf_regwrite), 32'd0);
          chk("rf_rd_hold", 32'(rf_rd), 32'(last_rd));
          chk("rf_writedata_hold", rf_writedata, last_d);
        end
      end
    end
  end
  initial begin
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 1'b1, 5'd3, 32'h100 + 32'(i), 1'b1, 5'd4, 32'h200 + 32'(i), 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
    idle(5'd7, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0, 5'd9);
    idle(5'd0, 5'd9);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 1'b1, 5'd2, 32'h300 + 32'(i), 1'b1, 5'd6, 32'h400, 1'b1, 5'd11, 5'd0, 5'd0);
    cyc(1'b0, 1'b1, 5'd2, 32'h3ff, 1'b1, 5'd6, 32'h400, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(5'd11, 5'd9);
    cyc(1'b1, 1'b1, 5'd2, 32'h500, 1'b1, 5'd6, 32'h600, 1'b0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 99) != 0),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
          1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
          1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    chk("write_queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning consecutive B-stall cycles before B is forced onto the write port.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports a_valid in 1, a_rd in 5, a_data in 32, a_ready out 1: pipeline writeback requester.
REQ-005 SHALL have ports b_valid in 1, b_rd in 5, b_data in 32, b_ready out 1: multi-cycle (mult/div/load) writeback requester.
REQ-006 SHALL have ports rf_regwrite out 1, rf_rd out 5, rf_writedata out 32: register-file write port, all registered.
REQ-007 SHALL have ports issue_valid in 1, issue_rd in 5: B-unit issue, marks rd pending.
REQ-008 SHALL have ports rs in 5, rt in 5, stall out 1: hazard query against pending destinations.
REQ-009 SHALL have port issue_err out 1: registered one-cycle pulse on issue to already-pending rd.

Function
REQ-010 SHALL complete a transfer on a requester only in cycles where its valid and ready are both 1.
REQ-011 SHALL drive a_ready/b_ready combinationally from state and valids; at most one ready high per cycle when both valids high.
REQ-012 SHALL implement FSM states NORMAL and FORCE_B.
REQ-013 In NORMAL: a_valid -> A granted; !a_valid & b_valid -> B granted; neither valid -> no grant.
REQ-014 In FORCE_B: b_ready = 1; a_ready = !b_valid.
REQ-015 SHALL count wait cycles (b_valid & !b_ready), saturating at MAX_WAIT; clear on B transfer or !b_valid.
REQ-016 NORMAL -> FORCE_B at the edge where wait count reaches MAX_WAIT; B thus wins on cycle MAX_WAIT+1 of waiting.
REQ-017 FORCE_B -> NORMAL after B transfer, or if b_valid drops (protocol violation, no write issued).
REQ-018 SHALL register granted rd/data to rf_rd/rf_writedata one cycle after transfer; rf_regwrite = 1 that cycle only if rd != 0.
REQ-019 Transfer with rd = 0 SHALL complete the handshake but leave rf_regwrite = 0.
REQ-020 rf_rd/rf_writedata SHALL hold last value when rf_regwrite = 0.
REQ-021 SHALL keep 32-bit pending vector; bit 0 constantly 0.
REQ-022 issue_valid with issue_rd != 0 SHALL set pending[issue_rd] at next edge.
REQ-023 B transfer SHALL clear pending[b_rd] at next edge; same-cycle issue and clear of same rd -> set wins.
REQ-024 stall SHALL be combinational: (rs != 0 & pending[rs]) | (rt != 0 & pending[rt]).
REQ-025 issue_err SHALL pulse when issue_valid, issue_rd != 0, and pending[issue_rd] already 1 and not being cleared that cycle.

Reset
REQ-026 rst_n low at an edge SHALL force: state NORMAL, wait count 0, pending all 0, rf_regwrite 0, rf_rd 0, rf_writedata 0, issue_err 0.
REQ-027 While rst_n low, a_ready and b_ready SHALL be 0; in-flight requests are dropped, not buffered.

Structure
REQ-028 FSM state encoding and register-index width (5) SHALL live in the shared pipeline package.
REQ-029 Scoreboard SHALL be a sub-module named regwrite_scoreboard (pending vector, stall, issue_err); arbiter FSM stays top-level.

Verification
REQ-030 A only: a_valid=1, a_rd=5, a_data=0x1234 -> a_ready=1; next cycle rf_regwrite=1, rf_rd=5, rf_writedata=0x1234.
REQ-031 Contention: a_valid and b_valid held high, MAX_WAIT=4 -> A granted cycles 1-4, B granted cycle 5, A resumes cycle 6.
REQ-032 rd zero: b_valid=1, b_rd=0, a_valid=0 -> b_ready=1, next cycle rf_regwrite=0.
REQ-033 Scoreboard: issue rd=7, then rs=7 -> stall=1; B writes rd=7 -> stall=0 cycle after transfer; issue rd=7 twice -> issue_err pulse.
REQ-034 Simultaneous issue rd=9 and B write rd=9 -> pending[9] remains 1, stall with rt=9.
REQ-035 Reset mid-FORCE_B: rst_n=0 for one edge -> state NORMAL, pending 0, rf_regwrite 0, both readies 0 during reset.
